// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - branch opcode encodings and condition helpers
package pc_branch_unit_pkg;

    typedef enum logic [2:0] {
        COND_B   = 3'b000,
        COND_BEQ = 3'b001,
        COND_BNE = 3'b010,
        COND_BLT = 3'b011,
        COND_BLE = 3'b100,
        COND_RET = 3'b101,
        COND_BLX = 3'b110,
        COND_BL  = 3'b111
    } cond_e;

    function automatic logic cond_taken(cond_e c, logic n, logic v, logic z);
        logic t;
        t = 1'b0;
        case (c)
            COND_B, COND_RET, COND_BLX, COND_BL: t = 1'b1;
            COND_BEQ: t = z;
            COND_BNE: t = !z;
            COND_BLT: t = (n != v);
            COND_BLE: t = (n != v) || z;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic cond_is_call(cond_e c);
        return (c == COND_BL) || (c == COND_BLX);
    endfunction

endpackage

// File: rtl/pc_branch_unit_ras_stack.sv
// rtl/pc_branch_unit_ras_stack.sv - circular return-address stack with sticky error flags
module ras_stack #(
    parameter int PC_W      = 9,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);

    localparam int AW = $clog2(RAS_DEPTH);

    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [AW-1:0]   sp;
    logic [AW:0]     count;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(RAS_DEPTH));
    assign dout  = mem[sp - AW'(1)];

    // sp always names the next write slot, so when full it also names the oldest entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            sp <= sp + AW'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + (AW+1)'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                sp    <= sp - AW'(1);
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[sp] <= din;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter with conditional branches, calls and returns
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter int              PC_W      = 9,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exec,
    input  logic            inc,
    input  logic [2:0]      cond,
    input  logic [PC_W-1:0] sximm8,
    input  logic [PC_W-1:0] rd_val,
    input  logic            V,
    input  logic            N,
    input  logic            Z,
    output logic [PC_W-1:0] pc,
    output logic            taken,
    output logic [PC_W-1:0] link,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_ovf,
    output logic            ras_unf
);

    cond_e           op;
    logic            br_taken;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] ras_top;

    assign op = cond_e'(cond);

    always_comb begin
        br_taken = exec && cond_taken(op, N, V, Z);
        push     = exec && cond_is_call(op);
        pop      = exec && (op == COND_RET);
        target   = pc + sximm8;
        if (op == COND_BLX) begin
            target = rd_val;
        end else if (op == COND_RET) begin
            // returning with nothing on the stack falls back to the register target
            target = ras_empty ? rd_val : ras_top;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            taken <= 1'b0;
            link  <= '0;
        end else begin
            taken <= br_taken;
            if (br_taken) begin
                pc <= target;
            end else if (!exec && inc) begin
                pc <= pc + PC_W'(1);
            end
            if (push) begin
                link <= pc;
            end
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc),
        .dout  (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - table-driven scoreboard bench for pc_branch_unit
module tb_pc_branch_unit;
    import pc_branch_unit_pkg::*;

    typedef struct {
        logic       ex;
        logic       in;
        logic [2:0] c;
        logic [8:0] imm;
        logic [8:0] rd;
        logic       n;
        logic       v;
        logic       z;
        logic [8:0] epc;
        logic       etk;
        logic [8:0] elk;
        logic       eem;
        logic       efu;
        logic       eov;
        logic       eun;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       exec = 1'b0;
    logic       inc = 1'b0;
    logic [2:0] cond = 3'b000;
    logic [8:0] sximm8 = '0;
    logic [8:0] rd_val = '0;
    logic       V = 1'b0;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic [8:0] pc;
    logic       taken;
    logic [8:0] link;
    logic       ras_empty, ras_full, ras_ovf, ras_unf;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pc_branch_unit #(.PC_W(9), .RAS_DEPTH(4), .RESET_PC(9'd0)) dut (
        .clk(clk), .reset(reset), .exec(exec), .inc(inc), .cond(cond),
        .sximm8(sximm8), .rd_val(rd_val), .V(V), .N(N), .Z(Z),
        .pc(pc), .taken(taken), .link(link), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic ex, logic in, logic [2:0] c, logic [8:0] imm,
                                logic [8:0] rd, logic n, logic v, logic z,
                                logic [8:0] epc, logic etk, logic [8:0] elk,
                                logic eem, logic efu, logic eov, logic eun);
        vec_t r;
        r.ex = ex; r.in = in; r.c = c; r.imm = imm; r.rd = rd;
        r.n = n; r.v = v; r.z = z;
        r.epc = epc; r.etk = etk; r.elk = elk;
        r.eem = eem; r.efu = efu; r.eov = eov; r.eun = eun;
        return r;
    endfunction

    task automatic check_state(string tag, logic [8:0] epc, logic etk, logic [8:0] elk,
                               logic eem, logic efu, logic eov, logic eun);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".taken"}, {8'd0, taken}, {8'd0, etk});
        chk({tag, ".link"}, link, elk);
        chk({tag, ".empty"}, {8'd0, ras_empty}, {8'd0, eem});
        chk({tag, ".full"}, {8'd0, ras_full}, {8'd0, efu});
        chk({tag, ".ovf"}, {8'd0, ras_ovf}, {8'd0, eov});
        chk({tag, ".unf"}, {8'd0, ras_unf}, {8'd0, eun});
    endtask

    task automatic apply(int idx, vec_t v);
        vec_t e;
        @(negedge clk);
        exec = v.ex; inc = v.in; cond = v.c; sximm8 = v.imm; rd_val = v.rd;
        N = v.n; V = v.v; Z = v.z;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_state($sformatf("v%0d", idx), e.epc, e.etk, e.elk, e.eem, e.efu, e.eov, e.eun);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //       ex    in    cond      imm      rd      n     v     z      pc      tk    link    em    fu    ov    un
        tbl.push_back(mk(1'b0, 1'b1, COND_B,   9'd0,   9'd0,  1'b0, 1'b0, 1'b0, 9'd1,   1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, COND_B,   9'd0,   9'd0,  1'b0, 1'b0, 1'b0, 9'd2,   1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, COND_B,   9'd0,   9'd0,  1'b0, 1'b0, 1'b0, 9'd3,   1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_B,   9'd508, 9'd0,  1'b0, 1'b0, 1'b0, 9'd511, 1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, COND_B,   9'd0,   9'd0,  1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_B,   9'd10,  9'd0,  1'b0, 1'b0, 1'b0, 9'd10,  1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BEQ, 9'h1FE, 9'd0,  1'b0, 1'b0, 1'b1, 9'd8,   1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_B,   9'd2,   9'd0,  1'b0, 1'b0, 1'b0, 9'd10,  1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BEQ, 9'h1FE, 9'd0,  1'b0, 1'b0, 1'b0, 9'd10,  1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, COND_B,   9'd7,   9'd0,  1'b0, 1'b0, 1'b0, 9'd10,  1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BNE, 9'd10,  9'd0,  1'b0, 1'b0, 1'b0, 9'd20,  1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BLT, 9'd5,   9'd0,  1'b1, 1'b0, 1'b0, 9'd25,  1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_B,   9'h1FB, 9'd0,  1'b0, 1'b0, 1'b0, 9'd20,  1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BLE, 9'd5,   9'd0,  1'b1, 1'b1, 1'b0, 9'd20,  1'b0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BLE, 9'd5,   9'd0,  1'b0, 1'b0, 1'b1, 9'd25,  1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_B,   9'd5,   9'd0,  1'b0, 1'b0, 1'b0, 9'd30,  1'b1, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BL,  9'd10,  9'd0,  1'b0, 1'b0, 1'b0, 9'd40,  1'b1, 9'd30, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_RET, 9'd0,   9'd99, 1'b0, 1'b0, 1'b0, 9'd30,  1'b1, 9'd30, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, COND_BLT, 9'd9,   9'd0,  1'b0, 1'b0, 1'b0, 9'd30,  1'b0, 9'd30, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, COND_B,   9'd20,  9'd0,  1'b0, 1'b0, 1'b0, 9'd50,  1'b1, 9'd30, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, COND_B,   9'd4,   9'd0,  1'b0, 1'b0, 1'b0, 9'd54,  1'b1, 9'd30, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BLX, 9'd3,   9'd100,1'b0, 1'b0, 1'b0, 9'd100, 1'b1, 9'd54, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_RET, 9'd0,   9'd99, 1'b0, 1'b0, 1'b0, 9'd54,  1'b1, 9'd54, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_B,   9'd459, 9'd0,  1'b0, 1'b0, 1'b0, 9'd1,   1'b1, 9'd54, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BL,  9'd1,   9'd0,  1'b0, 1'b0, 1'b0, 9'd2,   1'b1, 9'd1,  1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BL,  9'd1,   9'd0,  1'b0, 1'b0, 1'b0, 9'd3,   1'b1, 9'd2,  1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BL,  9'd1,   9'd0,  1'b0, 1'b0, 1'b0, 9'd4,   1'b1, 9'd3,  1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BL,  9'd1,   9'd0,  1'b0, 1'b0, 1'b0, 9'd5,   1'b1, 9'd4,  1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_BL,  9'd1,   9'd0,  1'b0, 1'b0, 1'b0, 9'd6,   1'b1, 9'd5,  1'b0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_RET, 9'd0,   9'd99, 1'b0, 1'b0, 1'b0, 9'd5,   1'b1, 9'd5,  1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_RET, 9'd0,   9'd99, 1'b0, 1'b0, 1'b0, 9'd4,   1'b1, 9'd5,  1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_RET, 9'd0,   9'd99, 1'b0, 1'b0, 1'b0, 9'd3,   1'b1, 9'd5,  1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_RET, 9'd0,   9'd99, 1'b0, 1'b0, 1'b0, 9'd2,   1'b1, 9'd5,  1'b1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, COND_RET, 9'd0,   9'd77, 1'b0, 1'b0, 1'b0, 9'd77,  1'b1, 9'd5,  1'b1, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, COND_B,   9'd0,   9'd0,  1'b0, 1'b0, 1'b0, 9'd78,  1'b0, 9'd5,  1'b1, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, COND_BL,  9'd3,   9'd0,  1'b0, 1'b0, 1'b0, 9'd81,  1'b1, 9'd78, 1'b0, 1'b0, 1'b1, 1'b1));

        // reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        check_state("reset", 9'd0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) apply(i, tbl[i]);

        // asynchronous reset in the middle of a call that is being issued
        @(negedge clk);
        exec = 1'b1; inc = 1'b0; cond = COND_BL; sximm8 = 9'd2;
        #2;
        reset = 1'b1;
        #1;
        check_state("async_rst", 9'd0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_state("rst_hold", 9'd0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        exec = 1'b0;
        reset = 1'b0;
        apply(100, mk(1'b0, 1'b1, COND_B, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0,
                      9'd1, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(101, mk(1'b1, 1'b0, COND_RET, 9'd0, 9'd33, 1'b0, 1'b0, 1'b0,
                      9'd33, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b1));

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
